// File: rtl/alu_mul_sequencer_if.sv
// alu_mul_sequencer_if: launch/result handshake plus shared-ALU request bus for the multiplier
interface alu_mul_sequencer_if #(parameter int WIDTH = 16);
    logic               start;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;
    logic               alu_req;
    logic               alu_gnt;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [3:0]         alu_op;
    logic [WIDTH-1:0]   alu_out;
    logic               alu_cout;

    modport master (
        input  start, mcand, mplier, alu_gnt, alu_out, alu_cout,
        output busy, done, product, alu_req, alu_a, alu_b, alu_op
    );

    modport slave (
        output start, mcand, mplier, alu_gnt, alu_out, alu_cout,
        input  busy, done, product, alu_req, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: 16x16->32 shift-add multiplier that borrows the shared ALU adder
module alu_mul_sequencer #(
    parameter int         WIDTH  = 16,
    parameter logic [3:0] ADD_OP = 4'b0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_mul_sequencer_if.master  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] hi, lo, mc;
    logic [4:0]       cnt;
    logic             adv;

    assign bus.product = {hi, lo};
    assign bus.alu_a   = hi;
    assign bus.alu_b   = mc;
    assign bus.alu_op  = ADD_OP;

    // State register; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state and handshake outputs; an iteration advances unless it needs the ALU and is denied
    always_comb begin
        state_next  = state;
        bus.busy    = state != IDLE;
        bus.done    = state == DONE;
        bus.alu_req = state == RUN && lo[0];
        adv         = state == RUN && (!lo[0] || bus.alu_gnt);
        case (state)
            IDLE:    state_next = bus.start ? RUN : IDLE;
            RUN:     state_next = (adv && cnt == 5'd15) ? DONE : RUN;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then shift (with ALU sum when the multiplier bit is set)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi  <= '0;
            lo  <= '0;
            mc  <= '0;
            cnt <= '0;
        end else if (state == IDLE && bus.start) begin
            hi  <= '0;
            lo  <= bus.mplier;
            mc  <= bus.mcand;
            cnt <= '0;
        end else if (adv) begin
            {hi, lo} <= {(lo[0] ? {bus.alu_cout, bus.alu_out} : {1'b0, hi}), lo[WIDTH-1:1]};
            cnt      <= cnt + 5'd1;
        end
    end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: directed vector table plus hand sequences for stalls, reset and busy-start
module tb_alu_mul_sequencer;
    logic clk = 0;
    logic rst_n = 0;
    int   checks = 0;
    int   errors = 0;
    int   deny_total = 0;
    int   denied;

    always #5 clk = ~clk;

    alu_mul_sequencer_if bus ();

    alu_mul_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ALU model: 17-bit sum for the add op, zero otherwise
    assign {bus.alu_cout, bus.alu_out} = (bus.alu_op == 4'b0000) ?
        ({1'b0, bus.alu_a} + {1'b0, bus.alu_b}) : 17'h0;

    // Arbiter model: deny the first deny_total requests of each operation
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) denied <= 0;
        else if (!bus.busy) denied <= 0;
        else if (bus.alu_req && !bus.alu_gnt) denied <= denied + 1;
    end
    assign bus.alu_gnt = denied >= deny_total;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          deny;
        logic [31:0] prod;
        int          cyc;
        logic        no_req;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.start  = 1;
        bus.mcand  = a;
        bus.mplier = b;
        @(negedge clk);
        bus.start  = 0;
        bus.mcand  = ~a;
        bus.mplier = ~b;
    endtask

    task automatic wait_done(input logic [15:0] mc, output int n, output logic saw_req);
        logic [31:0] prev_prod;
        logic        prev_stall;
        n          = 1;
        saw_req    = 0;
        prev_stall = 0;
        prev_prod  = bus.product;
        check("busy_run", {31'b0, bus.busy}, 32'd1);
        while (!bus.done && n < 200) begin
            if (bus.alu_req) begin
                saw_req = 1;
                check("alu_b_latched", {16'b0, bus.alu_b}, {16'b0, mc});
            end
            if (prev_stall) check("frozen", bus.product, prev_prod);
            prev_stall = bus.alu_req && !bus.alu_gnt;
            prev_prod  = bus.product;
            @(negedge clk);
            n++;
        end
        check("done_seen", {31'b0, bus.done}, 32'd1);
    endtask

    vec_t vecs[7];
    int   n;
    logic saw;

    initial begin
        vecs[0] = '{16'h0003, 16'h0005, 0, 32'h0000000F, 17, 1'b0};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 0, 32'hFFFE0001, 17, 1'b0};
        vecs[2] = '{16'h1234, 16'h0000, 0, 32'h00000000, 17, 1'b1};
        vecs[3] = '{16'h00FF, 16'h0003, 3, 32'h000002FD, 20, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 0, 32'h40000000, 17, 1'b0};
        vecs[5] = '{16'hABCD, 16'h0001, 0, 32'h0000ABCD, 17, 1'b0};
        vecs[6] = '{16'h0001, 16'hFFFF, 2, 32'h0000FFFF, 19, 1'b0};

        bus.start  = 0;
        bus.mcand  = 0;
        bus.mplier = 0;
        #1;
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_product", bus.product, 32'd0);
        check("rst_req", {31'b0, bus.alu_req}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 7; i++) begin
            deny_total = vecs[i].deny;
            launch(vecs[i].a, vecs[i].b);
            wait_done(vecs[i].a, n, saw);
            check($sformatf("v%0d_product", i), bus.product, vecs[i].prod);
            check($sformatf("v%0d_cycles", i), n, vecs[i].cyc);
            if (vecs[i].deny > 0) check($sformatf("v%0d_denies", i), denied, vecs[i].deny);
            if (vecs[i].no_req) check($sformatf("v%0d_no_req", i), {31'b0, saw}, 32'd0);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), {31'b0, bus.done}, 32'd0);
            check($sformatf("v%0d_idle", i), {31'b0, bus.busy}, 32'd0);
            check($sformatf("v%0d_hold", i), bus.product, vecs[i].prod);
        end
        deny_total = 0;

        // Asynchronous reset in the middle of an operation
        launch(16'h0101, 16'hFFFF);
        repeat (7) @(negedge clk);
        check("t5_busy_pre", {31'b0, bus.busy}, 32'd1);
        rst_n = 0;
        #1;
        check("t5_busy", {31'b0, bus.busy}, 32'd0);
        check("t5_done", {31'b0, bus.done}, 32'd0);
        check("t5_product", bus.product, 32'd0);
        check("t5_req", {31'b0, bus.alu_req}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        launch(16'h0007, 16'h0009);
        wait_done(16'h0007, n, saw);
        check("t5_new_product", bus.product, 32'h0000003F);
        check("t5_new_cycles", n, 17);

        // Start held through RUN and DONE is ignored, then accepted in the following IDLE
        launch(16'h0012, 16'h0034);
        bus.start  = 1;
        bus.mcand  = 16'h0005;
        bus.mplier = 16'h0006;
        wait_done(16'h0012, n, saw);
        check("t6_first_product", bus.product, 32'h000003A8);
        check("t6_first_cycles", n, 17);
        @(negedge clk);
        check("t6_idle", {31'b0, bus.busy}, 32'd0);
        @(negedge clk);
        check("t6_relaunch", {31'b0, bus.busy}, 32'd1);
        bus.start = 0;
        wait_done(16'h0005, n, saw);
        check("t6_second_product", bus.product, 32'h0000001E);
        check("t6_second_cycles", n, 17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
